interp_scheduler: RTL

//  Sequencer for the sinc interpolation datapath. Replaces the ad-hoc state machine and the separate phase counter.
//  - Per input sample from the PCM2706 receiver: preloads the filter, then steps it through every interpolation phase.
//  - Per phase: hands each 20-bit result to the PCM1702 shifter and waits for it to finish before the next phase.
//  - Queues one early input sample and flags any overrun.

---
 rtl/interp_scheduler_pkg.sv | 36 +++
 rtl/interp_cycle_cnt.sv | 32 +++
 rtl/interp_scheduler.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/interp_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// interp_scheduler_pkg
//   Shared definitions for the sinc interpolation sequencer and its helpers.
//   - sched_state_e : 3-bit FSM state encodings (IDLE..SHIFT)
//   - DEF_*         : default geometry, also reused by sinc_interp
//   - sched_out_t   : bundle of the state-decoded strobes
//   - max_int       : elaboration-time helper for sizing counters
// -----------------------------------------------------------------------------
package interp_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRELOAD = 3'd1,
    COMPUTE = 3'd2,
    FLUSH   = 3'd3,
    HANDOFF = 3'd4,
    SHIFT   = 3'd5
  } sched_state_e;

  localparam int DEF_N_PHASES   = 21;
  localparam int DEF_PHASE_W    = 5;
  localparam int DEF_TAP_CYCLES = 10;
  localparam int DEF_PIPE_LAT   = 2;

  typedef struct packed {
    logic pre_load;
    logic sinc_en;
    logic sample_rdy;
    logic busy;
  } sched_out_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/interp_cycle_cnt.sv
// -----------------------------------------------------------------------------
// interp_cycle_cnt
//   Loadable down-counter with terminal-count flag. Loading N-1 makes tc
//   assert on the N-th cycle after the load, so a state that exits on tc
//   lasts exactly N cycles.
// Ports
//   CLK, RST  : clock, async active-high reset
//   load      : load load_val this cycle (takes priority over counting)
//   load_val  : value to load
//   tc        : count has reached zero
// -----------------------------------------------------------------------------
module interp_cycle_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)             cnt <= '0;
    else if (load)       cnt <= load_val;
    else if (cnt != '0)  cnt <= cnt - CNT_W'(1);
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/interp_scheduler.sv
// -----------------------------------------------------------------------------
// interp_scheduler
//   Sequencer for the sinc interpolation datapath. For each input sample it
//   preloads the filter, then steps it through N_PHASES output phases: a
//   TAP_CYCLES MAC sweep, PIPE_LAT flush cycles, a handoff to the PCM1702
//   shifter, and a wait for the shift to finish. One early sample is queued;
//   a further one is dropped and flagged.
// Ports
//   CLK, RST     : clock, async active-high reset
//   data_rdy     : new input sample pulse
//   loaded       : shifter has latched outputSample
//   shift_done   : shifter finished shifting and LE
//   pre_load     : load filter delay line (1 cycle)
//   sinc_en      : MAC sweep enable
//   sinc_select  : current phase, 1..N_PHASES
//   sample_rdy   : outputSample valid, held until loaded
//   busy         : not IDLE
//   overrun      : input sample dropped (1-cycle pulse)
//   ovr_count    : saturating overrun count (only with
//                  INTERP_SCHED_OVERRUN_CNT_EN defined)
// -----------------------------------------------------------------------------
module interp_scheduler
  import interp_scheduler_pkg::*;
#(
  parameter int N_PHASES   = DEF_N_PHASES,
  parameter int PHASE_W    = DEF_PHASE_W,
  parameter int TAP_CYCLES = DEF_TAP_CYCLES,
  parameter int PIPE_LAT   = DEF_PIPE_LAT
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               data_rdy,
  input  logic               loaded,
  input  logic               shift_done,
  output logic               pre_load,
  output logic               sinc_en,
  output logic [PHASE_W-1:0] sinc_select,
  output logic               sample_rdy,
  output logic               busy,
  output logic               overrun
`ifdef INTERP_SCHED_OVERRUN_CNT_EN
  ,
  output logic [7:0]         ovr_count
`endif
);

  localparam int CNT_W = $clog2(max_int(TAP_CYCLES, PIPE_LAT) + 1);

  sched_state_e     state, state_nxt;
  logic [PHASE_W-1:0] sel_nxt;
  logic             pending, pending_nxt, ovr_nxt;
  logic             cnt_load, cnt_tc, step;
  logic [CNT_W-1:0] cnt_val;
  logic             last_phase;
  sched_out_t       outs;

  assign last_phase = (sinc_select == PHASE_W'(N_PHASES));

  // One counter times both COMPUTE and FLUSH; it is reloaded on entry.
  interp_cycle_cnt #(.CNT_W(CNT_W)) u_cycle_cnt (
    .CLK      (CLK),
    .RST      (RST),
    .load     (cnt_load),
    .load_val (cnt_val),
    .tc       (cnt_tc)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      sinc_select <= PHASE_W'(1);
      pending     <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state       <= state_nxt;
      sinc_select <= sel_nxt;
      pending     <= pending_nxt;
      overrun     <= ovr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sinc_select;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    step      = 1'b0;
    case (state)
      IDLE: if (data_rdy || pending) begin
        state_nxt = PRELOAD;
        sel_nxt   = PHASE_W'(1);
      end
      PRELOAD: begin
        state_nxt = COMPUTE;
        cnt_load  = 1'b1;
        cnt_val   = CNT_W'(TAP_CYCLES - 1);
      end
      COMPUTE: if (cnt_tc) begin
        state_nxt = FLUSH;
        cnt_load  = 1'b1;
        cnt_val   = CNT_W'(PIPE_LAT - 1);
      end
      FLUSH: if (cnt_tc) state_nxt = HANDOFF;
      // A shift_done arriving with loaded must not be lost: step directly.
      HANDOFF: if (loaded) begin
        if (shift_done) step = 1'b1;
        else            state_nxt = SHIFT;
      end
      SHIFT: if (shift_done) step = 1'b1;
      default: state_nxt = IDLE;
    endcase
    if (step) begin
      if (last_phase) begin
        state_nxt = IDLE;
        sel_nxt   = PHASE_W'(1);
      end else begin
        state_nxt = COMPUTE;
        sel_nxt   = sinc_select + PHASE_W'(1);
        cnt_load  = 1'b1;
        cnt_val   = CNT_W'(TAP_CYCLES - 1);
      end
    end
  end

  // Single-entry input queue. In IDLE the queued sample is consumed; a
  // fresh data_rdy in that same cycle takes over the queue slot.
  always_comb begin
    pending_nxt = pending;
    ovr_nxt     = 1'b0;
    if (state == IDLE) begin
      pending_nxt = pending & data_rdy;
    end else if (data_rdy) begin
      if (pending) ovr_nxt     = 1'b1;
      else         pending_nxt = 1'b1;
    end
  end

  always_comb begin
    outs            = '0;
    outs.pre_load   = (state == PRELOAD);
    outs.sinc_en    = (state == COMPUTE);
    outs.sample_rdy = (state == HANDOFF);
    outs.busy       = (state != IDLE);
  end

  assign pre_load   = outs.pre_load;
  assign sinc_en    = outs.sinc_en;
  assign sample_rdy = outs.sample_rdy;
  assign busy       = outs.busy;

`ifdef INTERP_SCHED_OVERRUN_CNT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                            ovr_count <= 8'd0;
    else if (overrun && ovr_count != 8'hFF) ovr_count <= ovr_count + 8'd1;
  end
`endif

endmodule
